// File: rtl/gate_bist.sv
// Self-test sequencer for a two-input gate: it drives vectors 00..11, checks each response against TRUTH_TABLE and counts mismatches.
// Optional macro GATE_BIST_FAILMASK_EN adds the fail_vec output, a per-vector mismatch mask.
module gate_bist #(
  parameter logic [3:0]  TRUTH_TABLE   = 4'b0111,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] num_errors
`ifdef GATE_BIST_FAILMASK_EN
  ,
  output logic [3:0] fail_vec
`endif
);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  localparam logic [3:0] LP_LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_vec;
  logic [3:0] r_cnt;
  logic       r_in1;
  logic       r_in2;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err;
`ifdef GATE_BIST_FAILMASK_EN
  logic [3:0] r_failVec;
`endif

  logic       w_mismatch;
  logic [2:0] w_errNext;
  logic [1:0] w_vecNext;

  // The error count saturates at 4, which is also the number of vectors.
  assign w_mismatch = (dut_out != TRUTH_TABLE[r_vec]);
  assign w_errNext  = (w_mismatch && (r_err != 3'd4)) ? r_err + 3'd1 : r_err;
  assign w_vecNext  = r_vec + 2'd1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_vec     <= 2'd0;
      r_cnt     <= 4'd0;
      r_in1     <= 1'b0;
      r_in2     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= 3'd0;
`ifdef GATE_BIST_FAILMASK_EN
      r_failVec <= 4'd0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state   <= APPLY;
            r_vec     <= 2'd0;
            r_cnt     <= 4'd0;
            r_in1     <= 1'b0;
            r_in2     <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= 3'd0;
`ifdef GATE_BIST_FAILMASK_EN
            r_failVec <= 4'd0;
`endif
          end
        end
        APPLY: begin
          if (r_cnt == LP_LAST_SETTLE) begin
            r_state <= CHECK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        CHECK: begin
          r_err <= w_errNext;
`ifdef GATE_BIST_FAILMASK_EN
          r_failVec[r_vec] <= w_mismatch;
`endif
          if (r_vec == 2'd3) begin
            r_state <= DONE;
            r_in1   <= 1'b0;
            r_in2   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_errNext == 3'd0);
          end else begin
            r_state <= APPLY;
            r_vec   <= w_vecNext;
            r_cnt   <= 4'd0;
            r_in1   <= w_vecNext[1];
            r_in2   <= w_vecNext[0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in1        = r_in1;
  assign in2        = r_in2;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign num_errors = r_err;
`ifdef GATE_BIST_FAILMASK_EN
  assign fail_vec   = r_failVec;
`endif

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: a default instance (SETTLE_CYCLES=1) and a slow instance (SETTLE_CYCLES=3), each driving a software gate model.
module tb_gate_bist;

  typedef enum int {M_NAND, M_STUCK0, M_STUCK1, M_AND, M_OR, M_XOR} model_t;

  typedef struct {
    model_t     mode;
    int         expErr;
    int         expPass;
    logic [3:0] expFail;
    string      name;
  } vec_t;

  logic             clock = 1'b0;
  logic [1:0]       resetn;
  logic [1:0]       start;
  logic [1:0]       dutOut;
  logic [1:0]       in1;
  logic [1:0]       in2;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0]       pass;
  logic [1:0][2:0]  numErr;
`ifdef GATE_BIST_FAILMASK_EN
  logic [1:0][3:0]  failVec;
`endif
  model_t           mode [2];

  int compared   = 0;
  int mismatched = 0;

  vec_t vecs [6];

  always #5 clock = ~clock;

  gate_bist u_dutFast (
    .clock      (clock),
    .resetn     (resetn[0]),
    .start      (start[0]),
    .dut_out    (dutOut[0]),
    .in1        (in1[0]),
    .in2        (in2[0]),
    .busy       (busy[0]),
    .done       (done[0]),
    .pass       (pass[0]),
    .num_errors (numErr[0])
`ifdef GATE_BIST_FAILMASK_EN
    ,
    .fail_vec   (failVec[0])
`endif
  );

  gate_bist #(.TRUTH_TABLE(4'b0111), .SETTLE_CYCLES(3)) u_dutSlow (
    .clock      (clock),
    .resetn     (resetn[1]),
    .start      (start[1]),
    .dut_out    (dutOut[1]),
    .in1        (in1[1]),
    .in2        (in2[1]),
    .busy       (busy[1]),
    .done       (done[1]),
    .pass       (pass[1]),
    .num_errors (numErr[1])
`ifdef GATE_BIST_FAILMASK_EN
    ,
    .fail_vec   (failVec[1])
`endif
  );

  function automatic logic gateModel(model_t m, logic a, logic b);
    case (m)
      M_NAND:   return ~(a & b);
      M_STUCK0: return 1'b0;
      M_STUCK1: return 1'b1;
      M_AND:    return a & b;
      M_OR:     return a | b;
      M_XOR:    return a ^ b;
      default:  return 1'b0;
    endcase
  endfunction

  always_comb begin
    dutOut    = 2'b00;
    dutOut[0] = gateModel(mode[0], in1[0], in2[0]);
    dutOut[1] = gateModel(mode[1], in1[1], in2[1]);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkIdleOutputs(input int idx, input string name);
    checkOutput({name, ":in"},     int'({in1[idx], in2[idx]}), 0);
    checkOutput({name, ":busy"},   int'(busy[idx]), 0);
    checkOutput({name, ":done"},   int'(done[idx]), 0);
    checkOutput({name, ":pass"},   int'(pass[idx]), 0);
    checkOutput({name, ":errors"}, int'(numErr[idx]), 0);
`ifdef GATE_BIST_FAILMASK_EN
    checkOutput({name, ":failvec"}, int'(failVec[idx]), 0);
`endif
  endtask

  // One full run: pulse start, follow the vector sequence cycle by cycle, then check the result on the final edge.
  task automatic applyStimulus(input int idx, input int settle, input model_t m,
                               input int expErr, input int expPass,
                               input logic [3:0] expFail, input string name);
    int total;
    total    = 4 * (settle + 1);
    mode[idx] = m;
    @(negedge clock);
    start[idx] = 1'b1;
    @(negedge clock);
    start[idx] = 1'b0;
    for (int k = 0; k < total; k++) begin
      if (k > 0) @(negedge clock);
      checkOutput({name, ":vec"},  int'({in1[idx], in2[idx]}), k / (settle + 1));
      checkOutput({name, ":busy"}, int'(busy[idx]), 1);
      checkOutput({name, ":done"}, int'(done[idx]), 0);
    end
    @(negedge clock);
    checkOutput({name, ":doneEnd"}, int'(done[idx]), 1);
    checkOutput({name, ":busyEnd"}, int'(busy[idx]), 0);
    checkOutput({name, ":inEnd"},   int'({in1[idx], in2[idx]}), 0);
    checkOutput({name, ":pass"},    int'(pass[idx]), expPass);
    checkOutput({name, ":errors"},  int'(numErr[idx]), expErr);
`ifdef GATE_BIST_FAILMASK_EN
    checkOutput({name, ":failvec"}, int'(failVec[idx]), int'(expFail));
`else
    if (expFail != expFail) $display("[TB] unreachable");
`endif
    @(negedge clock);
    checkOutput({name, ":doneHeld"},   int'(done[idx]), 1);
    checkOutput({name, ":errorsHeld"}, int'(numErr[idx]), expErr);
  endtask

  initial begin
    vecs[0] = '{M_NAND,   0, 1, 4'b0000, "nand"};
    vecs[1] = '{M_STUCK0, 3, 0, 4'b0111, "stuck0"};
    vecs[2] = '{M_AND,    4, 0, 4'b1111, "and"};
    vecs[3] = '{M_STUCK1, 1, 0, 4'b1000, "stuck1"};
    vecs[4] = '{M_OR,     2, 0, 4'b1001, "or"};
    vecs[5] = '{M_XOR,    1, 0, 4'b0001, "xor"};

    mode[0] = M_NAND;
    mode[1] = M_NAND;
    resetn  = 2'b00;
    start   = 2'b00;
    @(negedge clock);
    @(negedge clock);
    checkIdleOutputs(0, "resetFast");
    checkIdleOutputs(1, "resetSlow");
    resetn = 2'b11;
    @(negedge clock);
    @(negedge clock);
    checkOutput("idleAfterReset:busy", int'(busy[0]), 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, vecs[i].mode, vecs[i].expErr, vecs[i].expPass,
                    vecs[i].expFail, vecs[i].name);
    end

    // Reset in the middle of vector 2 with two errors already counted.
    mode[0] = M_STUCK0;
    @(negedge clock);
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("midRun:vecBefore",    int'({in1[0], in2[0]}), 2);
    checkOutput("midRun:errorsBefore", int'(numErr[0]), 2);
    resetn[0] = 1'b0;
    #1;
    checkIdleOutputs(0, "midRunReset");
    @(negedge clock);
    resetn[0] = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("afterReset:staysIdle", int'(busy[0]), 0);
    end
    applyStimulus(0, 1, M_NAND, 0, 1, 4'b0000, "freshAfterReset");

    // start held for three cycles mid-run must not restart or stretch the run.
    mode[0] = M_NAND;
    @(negedge clock);
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clock);
      start[0] = (e >= 2 && e <= 4);
      if (e == 5) checkOutput("startHeld:vecE5", int'({in1[0], in2[0]}), 2);
      if (e == 7) checkOutput("startHeld:doneE7", int'(done[0]), 0);
      if (e == 8) begin
        checkOutput("startHeld:doneE8", int'(done[0]), 1);
        checkOutput("startHeld:passE8", int'(pass[0]), 1);
      end
    end
    @(negedge clock);
    checkOutput("startHeld:doneHeld", int'(done[0]), 1);

    // start while in DONE restarts immediately.
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    checkOutput("restart:doneFalls", int'(done[0]), 0);
    checkOutput("restart:passFalls", int'(pass[0]), 0);
    checkOutput("restart:busy",      int'(busy[0]), 1);
    for (int e = 1; e <= 8; e++) begin
      @(negedge clock);
      if (e == 7) checkOutput("restart:doneE7", int'(done[0]), 0);
    end
    checkOutput("restart:doneE8", int'(done[0]), 1);
    checkOutput("restart:passE8", int'(pass[0]), 1);

    applyStimulus(1, 3, M_NAND,   0, 1, 4'b0000, "slowNand");
    applyStimulus(1, 3, M_STUCK0, 3, 0, 4'b0111, "slowStuck0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 Parameter TRUTH_TABLE, default 4'b0111: expected dut_out, indexed by {in1,in2}; the default is 2-input NAND.
REQ-002 Parameter SETTLE_CYCLES, default 1, legal range 1..15: cycles each vector is held before the check cycle.
REQ-003 Port clock  input  1: single clock; all state updates on rising edge.
REQ-004 Port resetn  input  1: asynchronous, active-low reset.
REQ-005 Port start  input  1: run request, sampled on rising edge.
REQ-006 Port dut_out  input  1: response of the gate under test.
REQ-007 Port in1  output  1: stimulus A to gate under test, registered.
REQ-008 Port in2  output  1: stimulus B to gate under test, registered.
REQ-009 Port busy  output  1: high while a run is in progress.
REQ-010 Port done  output  1: high when a completed result is held.
REQ-011 Port pass  output  1: done and num_errors == 0.
REQ-012 Port num_errors  output  3: mismatch count of the last or current run, range 0..4.

Function
REQ-013 FSM states: IDLE, APPLY, CHECK, DONE; 2-bit vector index vec; 4-bit settle counter.
REQ-014 IDLE or DONE with start=1 at an edge: go to APPLY, vec=0, counter=0, num_errors=0, done=0.
REQ-015 In APPLY and CHECK: in1=vec[1], in2=vec[0]; vector order is 00, 01, 10, 11.
REQ-016 In IDLE and DONE: in1=0, in2=0.
REQ-017 APPLY lasts exactly SETTLE_CYCLES cycles, then goes to CHECK.
REQ-018 CHECK lasts one cycle: on its closing edge, compare dut_out to TRUTH_TABLE[vec]; on mismatch, increment num_errors (saturating at 4).
REQ-019 CHECK with vec<3: go to APPLY with vec+1 and counter=0; CHECK with vec==3: go to DONE.
REQ-020 Latency: done rises on edge 4*(SETTLE_CYCLES+1) after the edge that sampled start (edge 8 at the default).
REQ-021 busy is high in APPLY and CHECK, low in IDLE and DONE.
REQ-022 In DONE, done, pass and num_errors are held until a new start or reset.
REQ-023 start while busy is ignored; the run is neither restarted nor extended.
REQ-024 start in DONE restarts the run; done and pass fall on that same edge.
REQ-025 dut_out is never sampled outside CHECK.

Reset
REQ-026 resetn low forces the FSM to IDLE immediately, without waiting for clock, from any state including mid-run.
REQ-027 Reset values: in1=0, in2=0, busy=0, done=0, pass=0, num_errors=0, vec=0, counter=0.
REQ-028 After resetn rises, the block stays in IDLE until start is sampled high.

Configuration
REQ-029 Macro GATE_BIST_FAILMASK_EN defined: add output port fail_vec (4 bits); bit k is set when vector k mismatched.
REQ-030 fail_vec clears on start and on reset, is held in DONE, and satisfies num_errors == popcount(fail_vec).
REQ-031 Macro GATE_BIST_FAILMASK_EN undefined: no fail_vec port and no fail_vec storage; all other behaviour is identical.

Verification
REQ-032 Correct NAND model, SETTLE_CYCLES=1, one-cycle start pulse -> in1/in2 = 00,01,10,11, each held 2 cycles; done=1 on edge 8; pass=1; num_errors=0.
REQ-033 dut_out stuck at 0 -> done with pass=0, num_errors=3, fail_vec=4'b0111 (with GATE_BIST_FAILMASK_EN).
REQ-034 AND model against the default table -> num_errors=4, pass=0, fail_vec=4'b1111.
REQ-035 resetn pulsed low during vector 2 -> all outputs 0 before the next edge; a new start then gives a fresh correct result.
REQ-036 start held high for 3 cycles mid-run -> done still on edge 8; start in DONE -> done falls on that edge and the run repeats.
REQ-037 SETTLE_CYCLES=3 -> each vector held 4 cycles; done on edge 16.
